// File: rtl/led_blink_scheduler_if.sv
// Request/status bundle between board status flags and one LED blink scheduler.
interface led_blink_scheduler_if #(
  parameter int unsigned NUM_SRC = 4
);
  localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] req;
  logic               force_on;
  logic               led;
  logic               active;
  logic [SRC_W-1:0]   cur_src;
  logic               code_done;

  modport master (
    output req, force_on,
    input  led, active, cur_src, code_done
  );

  modport slave (
    input  req, force_on,
    output led, active, cur_src, code_done
  );
endinterface

// File: rtl/led_blink_scheduler.sv
// Shares one status LED between NUM_SRC requesters using blink codes (k+1 flashes for requester k).
// Define STICKY_REQ_EN to latch requests so that single-cycle pulses are shown exactly once.
module led_blink_scheduler #(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned TICK_W    = 24,
  parameter int unsigned GAP_TICKS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  led_blink_scheduler_if.slave    bus
);
  localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned REM_W = $clog2(NUM_SRC + 1);
  localparam int unsigned GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [TICK_W-1:0]  cnt_q, cnt_d;
  logic [SRC_W-1:0]   cur_src_q, cur_src_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               hb_q, hb_d;
  logic               led_q, led_d;
  logic               active_q, active_d;
  logic               tick;
  logic               code_done;
  logic               fsm_led;
  logic [NUM_SRC-1:0] pending;
  logic               found;
  logic [SRC_W-1:0]   sel_src;
  logic [REM_W-1:0]   sel_rem;

  assign cnt_d = cnt_q + 1'b1;
  assign tick  = (cnt_q == '1);

`ifdef STICKY_REQ_EN
  logic [NUM_SRC-1:0] pending_q, pending_d;

  // Set wins: a request still high at code_done keeps its bit for another round.
  always_comb begin
    pending_d = pending_q | bus.req;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (code_done && (cur_src_q == SRC_W'(i)) && !bus.req[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;
`else
  assign pending = bus.req;
`endif

  // Lowest set index wins.
  always_comb begin
    found   = 1'b0;
    sel_src = '0;
    sel_rem = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!found && pending[i]) begin
        found   = 1'b1;
        sel_src = SRC_W'(i);
        sel_rem = REM_W'(i + 1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_src_d = cur_src_q;
    rem_d     = rem_q;
    gap_d     = gap_q;
    hb_d      = hb_q;
    code_done = 1'b0;
    fsm_led   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        fsm_led = hb_q;
        if (tick) begin
          if (!found) begin
            hb_d = ~hb_q;
          end else begin
            cur_src_d = sel_src;
            rem_d     = sel_rem;
            state_d   = ST_ON;
          end
        end
      end
      ST_ON: begin
        fsm_led = 1'b1;
        if (tick) begin
          state_d = ST_OFF;
        end
      end
      ST_OFF: begin
        if (tick) begin
          if (rem_q > REM_W'(1)) begin
            rem_d   = rem_q - REM_W'(1);
            state_d = ST_ON;
          end else begin
            gap_d   = GAP_W'(GAP_TICKS);
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (gap_q > GAP_W'(1)) begin
            gap_d = gap_q - GAP_W'(1);
          end else begin
            code_done = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    led_d    = bus.force_on ? 1'b1 : fsm_led;
    active_d = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cur_src_q <= '0;
      rem_q     <= '0;
      gap_q     <= '0;
      hb_q      <= 1'b0;
      led_q     <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_src_q <= cur_src_d;
      rem_q     <= rem_d;
      gap_q     <= gap_d;
      hb_q      <= hb_d;
      led_q     <= led_d;
      active_q  <= active_d;
    end
  end

  assign bus.led       = led_q;
  assign bus.active    = active_q;
  assign bus.cur_src   = cur_src_q;
  assign bus.code_done = code_done;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench for led_blink_scheduler with TICK_W=3 (tick every 8 cycles), GAP_TICKS=2, NUM_SRC=4.
module tb_led_blink_scheduler;
  logic clk;
  logic rst;
  int unsigned n_checks;
  int unsigned n_fail;
  int unsigned p;
  int unsigned rises;
  int unsigned dones;
  logic        led_prev;

  led_blink_scheduler_if #(.NUM_SRC(4)) bus ();

  led_blink_scheduler #(
    .NUM_SRC  (4),
    .TICK_W   (3),
    .GAP_TICKS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, p);
    end
  endtask

  // p counts posedges since reset release; samples are taken 1 time unit after each edge.
  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      p++;
      if (bus.led && !led_prev) rises++;
      led_prev = bus.led;
      if (bus.code_done) dones++;
    end
  endtask

  task automatic step_to(input int unsigned t);
    if (t > p) step(t - p);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.req      = '0;
    bus.force_on = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    p        = 0;
    rises    = 0;
    dones    = 0;
    led_prev = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    p        = 0;
    rises    = 0;
    dones    = 0;
    led_prev = 1'b0;
    rst          = 1'b1;
    bus.req      = '0;
    bus.force_on = 1'b0;
    #2;
    check_eq("rst_led", bus.led, 0);
    check_eq("rst_active", bus.active, 0);
    check_eq("rst_cur_src", bus.cur_src, 0);
    check_eq("rst_code_done", bus.code_done, 0);

    // Heartbeat with no requests
    do_reset();
    step_to(8);  check_eq("hb_led_c8", bus.led, 0);
    step_to(9);  check_eq("hb_led_c9", bus.led, 1);
                 check_eq("hb_active_c9", bus.active, 0);
    step_to(16); check_eq("hb_led_c16", bus.led, 1);
    step_to(17); check_eq("hb_led_c17", bus.led, 0);
    step_to(25); check_eq("hb_led_c25", bus.led, 1);

    // Requester 2 held: three flashes, gap, code_done, repeat
    do_reset();
    bus.req = 4'b0100;
    step_to(8);  check_eq("r2_cur_src_c8", bus.cur_src, 2);
                 check_eq("r2_active_c8", bus.active, 0);
    step_to(9);  check_eq("r2_led_c9", bus.led, 1);
                 check_eq("r2_active_c9", bus.active, 1);
    step_to(16); check_eq("r2_led_c16", bus.led, 1);
    step_to(17); check_eq("r2_led_c17", bus.led, 0);
    step_to(25); check_eq("r2_led_c25", bus.led, 1);
    step_to(41); check_eq("r2_led_c41", bus.led, 1);
    step_to(49); check_eq("r2_led_c49", bus.led, 0);
    step_to(57); check_eq("r2_led_c57", bus.led, 0);
                 check_eq("r2_active_c57", bus.active, 1);
    step_to(70); check_eq("r2_dones_c70", dones, 0);
    step_to(71); check_eq("r2_done_c71", bus.code_done, 1);
    step_to(72); check_eq("r2_done_c72", bus.code_done, 0);
                 check_eq("r2_flashes", rises, 3);
    step_to(73); check_eq("r2_active_c73", bus.active, 0);
                 check_eq("r2_led_c73", bus.led, 0);
    step_to(80); check_eq("r2_cur_src_c80", bus.cur_src, 2);
    step_to(81); check_eq("r2_led_c81", bus.led, 1);
                 check_eq("r2_active_c81", bus.active, 1);

    // Requesters 1 and 3, then 0 raised mid-code
    do_reset();
    bus.req = 4'b1010;
    step_to(8);  check_eq("mix_cur_src_c8", bus.cur_src, 1);
    step_to(20); bus.req = 4'b1011;
    step_to(50); check_eq("mix_cur_src_c50", bus.cur_src, 1);
    step_to(55); check_eq("mix_done_c55", bus.code_done, 1);
                 check_eq("mix_flashes", rises, 2);
    step_to(64); check_eq("mix_cur_src_c64", bus.cur_src, 0);
    step_to(65); check_eq("mix_led_c65", bus.led, 1);
    step_to(73); check_eq("mix_led_c73", bus.led, 0);
    step_to(81); check_eq("mix_led_c81", bus.led, 0);
    step_to(95); check_eq("mix_done_c95", bus.code_done, 1);

    // force_on across ON/OFF phases
    do_reset();
    bus.req = 4'b0100;
    step_to(12); bus.force_on = 1'b1;
    step_to(20); check_eq("fo_led_c20", bus.led, 1);
    step_to(36); check_eq("fo_led_c36", bus.led, 1);
    step_to(52); check_eq("fo_led_c52", bus.led, 1);
    step_to(60); bus.force_on = 1'b0;
    step_to(61); check_eq("fo_led_c61", bus.led, 0);
    step_to(70); check_eq("fo_done_c70", bus.code_done, 0);
    step_to(71); check_eq("fo_done_c71", bus.code_done, 1);

    // Reset during the second OFF of a three-flash code
    do_reset();
    bus.req = 4'b0100;
    step_to(35); check_eq("rmid_active_pre", bus.active, 1);
    rst = 1'b1;
    #1;
    check_eq("rmid_led", bus.led, 0);
    check_eq("rmid_active", bus.active, 0);
    check_eq("rmid_cur_src", bus.cur_src, 0);
    check_eq("rmid_done", bus.code_done, 0);
    @(posedge clk);
    #1;
    check_eq("rmid_done_held", bus.code_done, 0);
    check_eq("rmid_dones", dones, 0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    p        = 0;
    rises    = 0;
    dones    = 0;
    led_prev = 1'b0;
    step_to(7);  check_eq("rmid_active_c7", bus.active, 0);
    step_to(8);  check_eq("rmid_cur_src_c8", bus.cur_src, 2);
    step_to(9);  check_eq("rmid_led_c9", bus.led, 1);

    // Single-cycle pulse on requester 3
    do_reset();
    step_to(2);  bus.req = 4'b1000;
    step_to(3);  bus.req = 4'b0000;
`ifdef STICKY_REQ_EN
    step_to(8);  check_eq("st_cur_src_c8", bus.cur_src, 3);
    step_to(86); check_eq("st_dones_c86", dones, 0);
    step_to(87); check_eq("st_done_c87", bus.code_done, 1);
    step_to(88); check_eq("st_flashes", rises, 4);
    step_to(97); check_eq("st_led_c97", bus.led, 1);
                 check_eq("st_active_c97", bus.active, 0);
    step_to(200); check_eq("st_dones_c200", dones, 1);
                  check_eq("st_active_c200", bus.active, 0);
                  check_eq("st_cur_src_c200", bus.cur_src, 3);
`else
    step_to(9);  check_eq("ns_active_c9", bus.active, 0);
    step_to(40); check_eq("ns_dones_c40", dones, 0);
                 check_eq("ns_cur_src_c40", bus.cur_src, 0);
                 check_eq("ns_active_c40", bus.active, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
